// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, or runs one req/ack data-bus
// transaction per memory op while stalling the pipeline, then returns the write-back triple.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_memop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        excp_align_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2} state_e;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_B    = 2'd1;
    localparam logic [1:0] SZ_H    = 2'd2;
    localparam logic [1:0] SZ_W    = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Big-endian lane select and extension of returned read data.
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lane,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = lane[1] ? rd[15:0] : rd[31:16];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'd0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'd0, h};
            default: load_ext = rd;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        req_q, we_q, abort_q, bus_err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  sel_q, op_q;
    logic [1:0]  lane_q;

    logic [1:0]  size_s;
    logic        store_s, misalign_s, issue_s;
    logic [3:0]  sel_s;
    logic [31:0] st_data_s;

    // Decode the incoming op: access size, direction, alignment, lanes, store data.
    always_comb begin
        size_s    = SZ_NONE;
        store_s   = 1'b0;
        sel_s     = 4'b0000;
        st_data_s = mem_reg2_i;
        case (mem_memop_i)
            OP_LB, OP_LBU: size_s = SZ_B;
            OP_LH, OP_LHU: size_s = SZ_H;
            OP_LW:         size_s = SZ_W;
            OP_SB:         begin size_s = SZ_B; store_s = 1'b1; end
            OP_SH:         begin size_s = SZ_H; store_s = 1'b1; end
            OP_SW:         begin size_s = SZ_W; store_s = 1'b1; end
            default:       size_s = SZ_NONE;
        endcase
        case (size_s)
            SZ_B: begin
                st_data_s = {4{mem_reg2_i[7:0]}};
                case (mem_addr_i[1:0])
                    2'd0:    sel_s = 4'b1000;
                    2'd1:    sel_s = 4'b0100;
                    2'd2:    sel_s = 4'b0010;
                    default: sel_s = 4'b0001;
                endcase
            end
            SZ_H: begin
                st_data_s = {2{mem_reg2_i[15:0]}};
                sel_s     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            SZ_W:    sel_s = 4'b1111;
            default: sel_s = 4'b0000;
        endcase
        misalign_s = ((size_s == SZ_H) && mem_addr_i[0]) ||
                     ((size_s == SZ_W) && (mem_addr_i[1:0] != 2'b00));
        issue_s    = (size_s != SZ_NONE) && !misalign_s;
    end

    // Next-state logic; ack arriving on the timeout cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_s) state_d = S_BUS;
                else         state_d = S_IDLE;
            end
            S_BUS: begin
                if (dbus_ack_i || (cnt_q == CNT_LAST)) state_d = S_DONE;
                else                                   state_d = S_BUS;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Bus request registers, wait counter, captured read data and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;  req_q <= 1'b0;  we_q <= 1'b0;  abort_q <= 1'b0;  bus_err_q <= 1'b0;
            addr_q <= 32'd0;  wdata_q <= 32'd0;  rdata_q <= 32'd0;
            sel_q <= 4'd0;  op_q <= 4'd0;  lane_q <= 2'd0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (issue_s) begin
                        req_q   <= 1'b1;
                        we_q    <= store_s;
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        sel_q   <= sel_s;
                        wdata_q <= st_data_s;
                        cnt_q   <= 8'd0;
                        op_q    <= mem_memop_i;
                        lane_q  <= mem_addr_i[1:0];
                        abort_q <= 1'b0;
                    end
                end
                S_BUS: begin
                    if (dbus_ack_i) begin
                        rdata_q <= dbus_rdata_i;
                        req_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q     <= 1'b0;
                        abort_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output mux; everything is forced low while reset is held.
    always_comb begin
        wd_o = 5'd0;  wreg_o = 1'b0;  wdata_o = 32'd0;
        stallreq_o = 1'b0;  excp_align_o = 1'b0;  bus_err_o = 1'b0;
        dbus_req_o = 1'b0;  dbus_we_o = 1'b0;  dbus_addr_o = 32'd0;
        dbus_sel_o = 4'd0;  dbus_wdata_o = 32'd0;
        if (!rst) begin
            bus_err_o    = bus_err_q;
            dbus_req_o   = req_q;
            dbus_we_o    = we_q;
            dbus_addr_o  = addr_q;
            dbus_sel_o   = sel_q;
            dbus_wdata_o = wdata_q;
            wd_o         = mem_wd_i;
            case (state_q)
                S_IDLE: begin
                    wdata_o      = mem_wdata_i;
                    wreg_o       = (size_s == SZ_NONE) ? mem_wreg_i : 1'b0;
                    excp_align_o = misalign_s;
                    stallreq_o   = issue_s;
                end
                S_BUS:  stallreq_o = 1'b1;
                S_DONE: begin
                    wreg_o = abort_q ? 1'b0 : mem_wreg_i;
                    if ((op_q >= OP_LB) && (op_q <= OP_LW)) wdata_o = load_ext(op_q, lane_q, rdata_q);
                    else                                    wdata_o = mem_wdata_i;
                end
                default: wd_o = 5'd0;
            endcase
        end else begin
            wd_o = 5'd0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (TIMEOUT=4): pass-through, loads/stores, misalignment,
// bus timeout and mid-transaction reset, with hand-computed expectations.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_memop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o, excp_align_o, bus_err_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;

    int checks = 0;
    int errors = 0;

    int          st_n, req_n;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_sel;
    logic        c_we;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_memop_i(mem_memop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .excp_align_o(excp_align_o), .bus_err_o(bus_err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_memop_i = op;  mem_addr_i = addr;  mem_reg2_i = reg2;
        mem_wd_i = wd;  mem_wreg_i = wreg;  mem_wdata_i = wdata;
    endtask

    // Runs from the issue cycle to the first unstalled cycle; k<0 means never ack.
    task automatic run_txn(input int k, input logic [31:0] rd);
        st_n = 0;  req_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dbus_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    c_addr = dbus_addr_o;  c_wdata = dbus_wdata_o;  c_sel = dbus_sel_o;  c_we = dbus_we_o;
                end
            end
            if (stallreq_o) st_n++;
            else break;
            if (k >= 0 && req_n == k + 1) begin
                dbus_ack_i = 1'b1;  dbus_rdata_i = rd;
            end else begin
                dbus_ack_i = 1'b0;
            end
        end
        dbus_ack_i = 1'b0;
    endtask

    task automatic next_alu;
        @(posedge clk); #1;
        drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;  dbus_ack_i = 1'b0;  dbus_rdata_i = 32'd0;
        drive(4'd0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h12345678);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_req_stall", {30'd0, dbus_req_o, stallreq_o}, 32'd0);

        // ALU pass-through, also via an undefined memop code
        @(posedge clk); #1;
        rst = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFE0001);
        #1;
        chk("alu_wd", 32'(wd_o), 32'd3);
        chk("alu_wreg", 32'(wreg_o), 32'd1);
        chk("alu_wdata", wdata_o, 32'hCAFE0001);
        chk("alu_stall", 32'(stallreq_o), 32'd0);
        drive(4'd12, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0BADF00D);
        #1;
        chk("op12_wdata", wdata_o, 32'h0BADF00D);
        chk("op12_stall_excp", {30'd0, stallreq_o, excp_align_o}, 32'd0);

        // LW 0x100, ack on the 4th BUS cycle (coincides with timeout count)
        @(posedge clk); #1;
        drive(4'd5, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);
        #1;
        chk("lw_issue_stall", 32'(stallreq_o), 32'd1);
        chk("lw_issue_wreg", 32'(wreg_o), 32'd0);
        run_txn(3, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(st_n), 32'd5);
        chk("lw_sel", 32'(c_sel), 32'hF);
        chk("lw_addr", c_addr, 32'h100);
        chk("lw_we", 32'(c_we), 32'd0);
        chk("lw_wdata", wdata_o, 32'hDEADBEEF);
        chk("lw_wreg", 32'(wreg_o), 32'd1);
        chk("lw_wd", 32'(wd_o), 32'd7);
        chk("lw_buserr", 32'(bus_err_o), 32'd0);
        next_alu();

        // LB / LBU 0x101
        @(posedge clk); #1;
        drive(4'd1, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0);
        run_txn(0, 32'h11802233);
        chk("lb_stall_cycles", 32'(st_n), 32'd2);
        chk("lb_sel", 32'(c_sel), 32'h4);
        chk("lb_addr", c_addr, 32'h100);
        chk("lb_wdata", wdata_o, 32'hFFFFFF80);
        next_alu();
        @(posedge clk); #1;
        drive(4'd2, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0);
        run_txn(1, 32'h11802233);
        chk("lbu_stall_cycles", 32'(st_n), 32'd3);
        chk("lbu_wdata", wdata_o, 32'h00000080);
        next_alu();

        // LH 0x102 (low half, negative) and LHU 0x100 (high half)
        @(posedge clk); #1;
        drive(4'd3, 32'h102, 32'h0, 5'd1, 1'b1, 32'h0);
        run_txn(0, 32'h1180F233);
        chk("lh_sel", 32'(c_sel), 32'h3);
        chk("lh_wdata", wdata_o, 32'hFFFFF233);
        next_alu();
        @(posedge clk); #1;
        drive(4'd4, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0);
        run_txn(0, 32'h9180F233);
        chk("lhu_sel", 32'(c_sel), 32'hC);
        chk("lhu_wdata", wdata_o, 32'h00009180);
        next_alu();

        // SH 0x102 and SB 0x103
        @(posedge clk); #1;
        drive(4'd7, 32'h102, 32'h0000ABCD, 5'd2, 1'b0, 32'h55);
        run_txn(1, 32'h0);
        chk("sh_we", 32'(c_we), 32'd1);
        chk("sh_sel", 32'(c_sel), 32'h3);
        chk("sh_dwdata", c_wdata, 32'hABCDABCD);
        chk("sh_wreg", 32'(wreg_o), 32'd0);
        next_alu();
        @(posedge clk); #1;
        drive(4'd6, 32'h103, 32'h12345678, 5'd6, 1'b1, 32'h00000777);
        run_txn(0, 32'h0);
        chk("sb_sel", 32'(c_sel), 32'h1);
        chk("sb_dwdata", c_wdata, 32'h78787878);
        chk("sb_wreg", 32'(wreg_o), 32'd1);
        chk("sb_wdata", wdata_o, 32'h00000777);
        next_alu();

        // Misaligned LW 0x102: flagged, never reaches the bus
        @(posedge clk); #1;
        drive(4'd5, 32'h102, 32'h0, 5'd5, 1'b1, 32'h0);
        run_txn(-1, 32'h0);
        chk("mis_excp", 32'(excp_align_o), 32'd1);
        chk("mis_stall_cycles", 32'(st_n), 32'd0);
        chk("mis_wreg", 32'(wreg_o), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mis_no_req", 32'(dbus_req_o), 32'd0);
        end
        next_alu();

        // Timeout: no ack, req high for TIMEOUT cycles, single bus_err pulse
        @(posedge clk); #1;
        drive(4'd5, 32'h200, 32'h0, 5'd10, 1'b1, 32'h0);
        run_txn(-1, 32'h0);
        chk("to_req_cycles", 32'(req_n), 32'd4);
        chk("to_stall_cycles", 32'(st_n), 32'd5);
        chk("to_buserr", 32'(bus_err_o), 32'd1);
        chk("to_wreg", 32'(wreg_o), 32'd0);
        next_alu();
        @(negedge clk);
        chk("to_buserr_pulse", 32'(bus_err_o), 32'd0);

        // Reset in the middle of a bus transaction
        @(posedge clk); #1;
        drive(4'd5, 32'h300, 32'h0, 5'd11, 1'b1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rb_req_up", 32'(dbus_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rb_req_after", 32'(dbus_req_o), 32'd0);
        chk("rb_outs", {27'd0, wreg_o, stallreq_o, bus_err_o, excp_align_o, 1'b0}, 32'd0);
        rst = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 5'd13, 1'b1, 32'hA5A5A5A5);
        #1;
        chk("rb_alu_wdata", wdata_o, 32'hA5A5A5A5);
        chk("rb_alu_wreg", 32'(wreg_o), 32'd1);
        chk("rb_alu_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        chk("rb_no_buserr", 32'(bus_err_o), 32'd0);
        chk("rb_still_idle", 32'(dbus_req_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
